prog_mem_loader: RTL
====================

PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

Interface
REQ-001 SHALL use widths from the shared header: D_WIDTH = 32, SA_WIDTH = 4 (16 words).
REQ-002 Clk  input  1  clock; all state changes on rising edge.
REQ-003 Rst  input  1  reset, synchronous, active-high.
REQ-004 LdByte  input  8  program byte from host loader.
REQ-005 LdValid  input  1  LdByte valid this cycle.
REQ-006 LdLast  input  1  qualifies LdByte as final program byte.
REQ-007 LdReady  output  1  loader accepts a byte this cycle.
REQ-008 Addr  input  SA_WIDTH  processor word address.
REQ-009 En  input  1  processor access enable.
REQ-010 RW  input  1  0 = read, 1 = write.
REQ-011 WData  input  D_WIDTH  processor write data.
REQ-012 Data  output  D_WIDTH  registered read data to processor.
REQ-013 ProgLoaded  output  1  high in S_RUN; drives processor reset release (processor Rst = ~ProgLoaded).
REQ-014 WordCnt  output  5  words written during load, 0..16.

Function
REQ-015 SHALL hold a 16 x D_WIDTH storage array and a 3-state FSM: S_CLEAR, S_LOAD, S_RUN.
REQ-016 S_CLEAR: write 0 to word ClrPtr per cycle, ClrPtr 0..15; after word 15 (16 cycles) -> S_LOAD; LdReady = 0.
REQ-017 S_LOAD: LdReady = 1; a byte is accepted only when LdValid & LdReady.
REQ-018 Accepted bytes SHALL assemble big-endian: 1st byte -> bits 31:24, 2nd -> 23:16, 3rd -> 15:8, 4th -> 7:0.
REQ-019 On the 4th accepted byte the word SHALL be written to address WrPtr in that same edge; WrPtr and WordCnt increment; byte counter returns to 0.
REQ-020 Accepted byte with LdLast = 1: unfilled low bytes padded with 0, word written at WrPtr, WordCnt increments, next state S_RUN.
REQ-021 LdLast on a byte that completes a word: exactly one write, no extra zero word.
REQ-022 When WordCnt reaches 16: next state S_RUN regardless of LdLast; further bytes are not accepted (LdReady = 0).
REQ-023 LdValid with LdReady = 0 SHALL be ignored, no state change.
REQ-024 S_RUN: LdReady = 0; ProgLoaded = 1; S_RUN is left only via Rst.
REQ-025 S_RUN read, En = 1 and RW = 0: Data = mem[Addr] at the next rising edge (1-cycle latency).
REQ-026 S_RUN write, En = 1 and RW = 1: mem[Addr] <= WData at the edge; Data unchanged.
REQ-027 En = 0, or any state other than S_RUN: Data holds its previous value; processor accesses are ignored.
REQ-028 Read of a word not loaded returns 0 (cleared in S_CLEAR).

Reset
REQ-029 Rst = 1 at an edge: state <- S_CLEAR, ClrPtr = 0, WrPtr = 0, byte counter = 0, WordCnt = 0, Data = 0, LdReady = 0, ProgLoaded = 0.
REQ-030 Rst asserted mid-load or mid-run SHALL discard the partial word and re-clear all 16 words.

Configuration
REQ-031 Macro PMEM_PARITY_EN: when defined, each word stores an extra even-parity bit computed at write (load or processor), adds output ParErr (1 bit), and sets ParErr = 1 in the same cycle Data updates if the read word's parity mismatches; ParErr is cleared on the next good read and on Rst.
REQ-032 Without PMEM_PARITY_EN: no parity storage, no ParErr port; behaviour otherwise identical.

Verification
REQ-033 Rst for 1 cycle -> LdReady rises exactly 16 cycles later; WordCnt = 0; ProgLoaded = 0.
REQ-034 Load bytes 20,01,00,05 then 00,22,18,20 with LdLast on the last byte -> WordCnt = 2, ProgLoaded = 1; read Addr 0 -> Data = 32'h20010005 one cycle later; Addr 1 -> 32'h00221820; Addr 2 -> 0.
REQ-035 Load bytes AB,CD with LdLast on CD -> mem[0] = 32'hABCD0000, WordCnt = 1.
REQ-036 Stream 70 bytes with no LdLast -> after 64 accepted bytes WordCnt = 16, S_RUN, remaining 6 bytes ignored (LdReady = 0).
REQ-037 In S_RUN write Addr 3 = 32'hDEADBEEF, read Addr 3 next cycle -> Data = 32'hDEADBEEF; assert Rst after 2 bytes of a new load -> Data = 0, Addr 3 reads 0 after re-load.
REQ-038 With PMEM_PARITY_EN defined, force one stored bit flip via the bench, read that word -> ParErr = 1; read a good word -> ParErr = 0.

Source files
------------

// File: rtl/prog_mem_loader.sv
// prog_mem_loader
// ---------------
// A 16-word program memory that a host fills one byte at a time. Once it is
// loaded, the processor uses it as a single-port RAM.
//
// Life cycle:
//   S_CLEAR : 16 cycles. One word is zeroed per cycle, so every word that is
//             never loaded reads back as 0.
//   S_LOAD  : Host bytes are packed big-endian into 32-bit words. A word is
//             written when its 4th byte arrives, or early on LdLast, in which
//             case the missing low bytes are zero.
//   S_RUN   : The processor has read/write access. ProgLoaded = 1 here and
//             releases the processor from reset. Only Rst leaves this state.
//
// Ports:
//   Clk, Rst             clock, synchronous active-high reset
//   LdByte/LdValid/LdLast host byte stream; LdReady = byte accepted this cycle
//   Addr/En/RW/WData     processor access (RW: 0 = read, 1 = write)
//   Data                 registered read data, 1-cycle latency
//   ProgLoaded           high in S_RUN
//   WordCnt              words written during the load, 0..16
//   ParErr               (PMEM_PARITY_EN only) parity mismatch on the last read
//
// Build option: define PMEM_PARITY_EN to store an even-parity bit with every
// word and to add the ParErr output.

module prog_mem_loader #(
    parameter int D_WIDTH  = 32,
    parameter int SA_WIDTH = 4
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [7:0]          LdByte,
    input  logic                LdValid,
    input  logic                LdLast,
    output logic                LdReady,
    input  logic [SA_WIDTH-1:0] Addr,
    input  logic                En,
    input  logic                RW,
    input  logic [D_WIDTH-1:0]  WData,
    output logic [D_WIDTH-1:0]  Data,
    output logic                ProgLoaded,
`ifdef PMEM_PARITY_EN
    output logic                ParErr,
`endif
    output logic [4:0]          WordCnt
);

    localparam int DEPTH = 1 << SA_WIDTH;

`ifdef PMEM_PARITY_EN
    localparam int M_WIDTH = D_WIDTH + 1;
`else
    localparam int M_WIDTH = D_WIDTH;
`endif

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t                state_q;
    logic [SA_WIDTH-1:0]   ClrPtr_q;
    logic [SA_WIDTH-1:0]   WrPtr_q;
    logic [1:0]            ByteCnt_q;
    logic [D_WIDTH-1:0]    Asm_q;
    logic [4:0]            WordCnt_q;
    logic                  LdReady_q;
    logic                  ProgLoaded_q;
    logic [D_WIDTH-1:0]    Data_q;
`ifdef PMEM_PARITY_EN
    logic                  ParErr_q;
`endif

    logic [M_WIDTH-1:0]    mem_q [DEPTH];

    logic [D_WIDTH-1:0]    AsmWord_d;
    logic                  accept;
    logic                  word_done;
    logic [4:0]            wc_next;
    logic                  mem_we;
    logic [SA_WIDTH-1:0]   mem_waddr;
    logic [D_WIDTH-1:0]    mem_wdata;
    logic [M_WIDTH-1:0]    rd_word;

    // LdReady_q is set only in S_LOAD, so it also gates acceptance. Bytes
    // offered in any other state are dropped.
    assign accept    = LdValid & LdReady_q;
    assign word_done = accept & ((ByteCnt_q == 2'd3) | LdLast);
    assign wc_next   = WordCnt_q + 5'd1;
    assign rd_word   = mem_q[Addr];

    // Merge the incoming byte into its big-endian lane. Asm_q keeps the lanes
    // that are not filled yet at zero, which also gives the LdLast padding.
    always_comb begin
        AsmWord_d = Asm_q;
        case (ByteCnt_q)
            2'd0:    AsmWord_d[31:24] = LdByte;
            2'd1:    AsmWord_d[23:16] = LdByte;
            2'd2:    AsmWord_d[15:8]  = LdByte;
            default: AsmWord_d[7:0]   = LdByte;
        endcase
    end

    // The memory has one write port, shared by the clear sweep, the loader
    // and processor writes. They cannot collide because each belongs to a
    // different state.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = ClrPtr_q;
        mem_wdata = '0;
        if (!Rst) begin
            case (state_q)
                S_CLEAR: begin
                    mem_we    = 1'b1;
                    mem_waddr = ClrPtr_q;
                end
                S_LOAD: begin
                    if (word_done) begin
                        mem_we    = 1'b1;
                        mem_waddr = WrPtr_q;
                        mem_wdata = AsmWord_d;
                    end
                end
                S_RUN: begin
                    if (En && RW) begin
                        mem_we    = 1'b1;
                        mem_waddr = Addr;
                        mem_wdata = WData;
                    end
                end
                default: mem_we = 1'b0;
            endcase
        end
    end

    // Storage has no reset. The S_CLEAR sweep that follows every reset puts
    // it into a known state.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
`ifdef PMEM_PARITY_EN
            mem_q[mem_waddr] <= {^mem_wdata, mem_wdata};
`else
            mem_q[mem_waddr] <= mem_wdata;
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= S_CLEAR;
            ClrPtr_q     <= '0;
            WrPtr_q      <= '0;
            ByteCnt_q    <= 2'd0;
            Asm_q        <= '0;
            WordCnt_q    <= 5'd0;
            LdReady_q    <= 1'b0;
            ProgLoaded_q <= 1'b0;
            Data_q       <= '0;
`ifdef PMEM_PARITY_EN
            ParErr_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_CLEAR: begin
                    ClrPtr_q <= ClrPtr_q + 1'b1;
                    if (ClrPtr_q == {SA_WIDTH{1'b1}}) begin
                        state_q   <= S_LOAD;
                        LdReady_q <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        if (word_done) begin
                            Asm_q     <= '0;
                            ByteCnt_q <= 2'd0;
                            WrPtr_q   <= WrPtr_q + 1'b1;
                            WordCnt_q <= wc_next;
                            // A full memory ends the load even without LdLast.
                            if (LdLast || (wc_next == 5'd16)) begin
                                state_q      <= S_RUN;
                                LdReady_q    <= 1'b0;
                                ProgLoaded_q <= 1'b1;
                            end
                        end else begin
                            Asm_q     <= AsmWord_d;
                            ByteCnt_q <= ByteCnt_q + 2'd1;
                        end
                    end
                end
                S_RUN: begin
                    if (En && !RW) begin
                        Data_q   <= rd_word[D_WIDTH-1:0];
`ifdef PMEM_PARITY_EN
                        // Even parity over the data bits plus the stored
                        // bit is 0 for a good word.
                        ParErr_q <= ^rd_word;
`endif
                    end
                end
                default: state_q <= S_CLEAR;
            endcase
        end
    end

    assign LdReady    = LdReady_q;
    assign ProgLoaded = ProgLoaded_q;
    assign WordCnt    = WordCnt_q;
    assign Data       = Data_q;
`ifdef PMEM_PARITY_EN
    assign ParErr     = ParErr_q;
`endif

endmodule
